// File: rtl/flag_cond_pkg.sv
// Shared definitions for the execute-stage condition unit:
// condition codes, flag bit positions and IT state encoding.
package flag_cond_pkg;

   localparam logic [3:0] EQ = 4'b0000;
   localparam logic [3:0] NE = 4'b0001;
   localparam logic [3:0] CS = 4'b0010;
   localparam logic [3:0] CC = 4'b0011;
   localparam logic [3:0] MI = 4'b0100;
   localparam logic [3:0] PL = 4'b0101;
   localparam logic [3:0] VS = 4'b0110;
   localparam logic [3:0] VC = 4'b0111;
   localparam logic [3:0] HI = 4'b1000;
   localparam logic [3:0] LS = 4'b1001;
   localparam logic [3:0] GE = 4'b1010;
   localparam logic [3:0] LT = 4'b1011;
   localparam logic [3:0] GT = 4'b1100;
   localparam logic [3:0] LE = 4'b1101;
   localparam logic [3:0] AL = 4'b1110;
   localparam logic [3:0] NV = 4'b1111;

   localparam int FN = 3;
   localparam int FZ = 2;
   localparam int FC = 1;
   localparam int FV = 0;

   typedef enum logic {
      IT_IDLE,
      IT_ACTIVE
   } it_state_t;

endpackage

// File: rtl/flag_cond_unit_cond_check.sv
// Combinational ARM condition evaluation against N,Z,C,V.
// Codes 1110 and 1111 always pass.
module cond_check
   import flag_cond_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);

   logic n, z, c, v;

   assign n = flags[FN];
   assign z = flags[FZ];
   assign c = flags[FC];
   assign v = flags[FV];

   always_comb begin
      pass = 1'b1;
      unique case (cond)
         EQ: pass = z;
         NE: pass = !z;
         CS: pass = c;
         CC: pass = !c;
         MI: pass = n;
         PL: pass = !n;
         VS: pass = v;
         VC: pass = !v;
         HI: pass = c && !z;
         LS: pass = !c || z;
         GE: pass = (n == v);
         LT: pass = (n != v);
         GT: pass = !z && (n == v);
         LE: pass = z || (n != v);
         default: pass = 1'b1;
      endcase
   end

endmodule

// File: rtl/flag_cond_unit.sv
// Execute-stage condition unit: grouped flag register, shadow copy
// for exception entry/return, and IT-block predication.
module flag_cond_unit
   import flag_cond_pkg::*;
#(
   parameter int FLAG_W   = 4,
   parameter int NGROUPS  = 2,
   parameter int IT_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          StallE,
   input  logic                          FlushE,
   input  logic [3:0]                    CondE,
   input  logic [NGROUPS-1:0]            FlagWriteE,
   input  logic [FLAG_W-1:0]             ALUFlags,
   input  logic                          ITStartE,
   input  logic [3:0]                    ITCondE,
   input  logic [$clog2(IT_DEPTH):0]     ITLenE,
   input  logic [IT_DEPTH-1:0]           ITMaskE,
   input  logic                          SaveE,
   input  logic                          RestoreE,
   output logic [FLAG_W-1:0]             Flags,
   output logic                          CondExE,
   output logic                          ITActive,
   output logic [$clog2(IT_DEPTH):0]     ITRemain
);

   localparam int GW = FLAG_W / NGROUPS;
   localparam int RW = $clog2(IT_DEPTH) + 1;
   localparam int SW = (IT_DEPTH > 1) ? $clog2(IT_DEPTH) : 1;

   logic [FLAG_W-1:0]   flags_q, flags_n, shadow_q;
   it_state_t           state, state_n;
   logic [3:0]          itcond, itcond_n;
   logic [IT_DEPTH-1:0] mask, mask_n;
   logic [SW-1:0]       slot, slot_n;
   logic [RW-1:0]       remain, remain_n;
   logic                advance, it_ok, pass;
   logic [3:0]          effcond;

   assign advance = !StallE && !FlushE;
   assign it_ok   = (ITLenE != '0) && (ITLenE <= RW'(IT_DEPTH));

   always_comb begin
      effcond = CondE;
      if (state == IT_ACTIVE)
         effcond = {itcond[3:1], itcond[0] ^ ~mask[slot]};
   end

   cond_check u_check (
      .cond  (effcond),
      .flags (flags_q[3:0]),
      .pass  (pass)
   );

   assign CondExE = !FlushE && pass;

   // restore wins over any group write in the same cycle
   for (genvar g = 0; g < NGROUPS; g++) begin : g_grp
      assign flags_n[g*GW +: GW] =
         !advance                     ? flags_q[g*GW +: GW]  :
         RestoreE                     ? shadow_q[g*GW +: GW] :
         (FlagWriteE[g] && CondExE)   ? ALUFlags[g*GW +: GW] :
                                        flags_q[g*GW +: GW];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q  <= '0;
         shadow_q <= '0;
      end else begin
         flags_q <= flags_n;
         if (advance && SaveE)
            shadow_q <= flags_q;
      end
   end

   always_comb begin
      state_n  = state;
      itcond_n = itcond;
      mask_n   = mask;
      slot_n   = slot;
      remain_n = remain;
      unique case (state)
         IT_IDLE: begin
            if (advance && ITStartE && it_ok) begin
               state_n  = IT_ACTIVE;
               itcond_n = ITCondE;
               mask_n   = ITMaskE | IT_DEPTH'(1);
               slot_n   = '0;
               remain_n = ITLenE;
            end
         end
         IT_ACTIVE: begin
            if (advance) begin
               slot_n   = slot + SW'(1);
               remain_n = remain - RW'(1);
               if (remain == RW'(1))
                  state_n = IT_IDLE;
            end
         end
         default: state_n = IT_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IT_IDLE;
         itcond <= '0;
         mask   <= '0;
         slot   <= '0;
         remain <= '0;
      end else begin
         state  <= state_n;
         itcond <= itcond_n;
         mask   <= mask_n;
         slot   <= slot_n;
         remain <= remain_n;
      end
   end

   assign Flags    = flags_q;
   assign ITActive = (state == IT_ACTIVE);
   assign ITRemain = remain;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Directed bench for flag_cond_unit: flag groups, stall/flush,
// IT predication, save/restore and reset behaviour.
module tb_flag_cond_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       StallE, FlushE;
   logic [3:0] CondE;
   logic [1:0] FlagWriteE;
   logic [3:0] ALUFlags;
   logic       ITStartE;
   logic [3:0] ITCondE;
   logic [2:0] ITLenE;
   logic [3:0] ITMaskE;
   logic       SaveE, RestoreE;
   logic [3:0] Flags;
   logic       CondExE;
   logic       ITActive;
   logic [2:0] ITRemain;

   int checks = 0;
   int errors = 0;

   flag_cond_unit dut (
      .clk        (clk),
      .reset      (reset),
      .StallE     (StallE),
      .FlushE     (FlushE),
      .CondE      (CondE),
      .FlagWriteE (FlagWriteE),
      .ALUFlags   (ALUFlags),
      .ITStartE   (ITStartE),
      .ITCondE    (ITCondE),
      .ITLenE     (ITLenE),
      .ITMaskE    (ITMaskE),
      .SaveE      (SaveE),
      .RestoreE   (RestoreE),
      .Flags      (Flags),
      .CondExE    (CondExE),
      .ITActive   (ITActive),
      .ITRemain   (ITRemain)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   logic [3:0] ccode [10];
   logic       cexp  [10];

   initial begin
      reset = 1'b1; StallE = 0; FlushE = 0; CondE = 4'b1110;
      FlagWriteE = 0; ALUFlags = 0; ITStartE = 0; ITCondE = 0;
      ITLenE = 0; ITMaskE = 0; SaveE = 0; RestoreE = 0;
      cyc(); cyc();
      reset = 1'b0;
      settle();
      chk("rst_flags", 8'(Flags), 8'h0);
      chk("rst_itact", 8'(ITActive), 8'h0);
      chk("rst_itrem", 8'(ITRemain), 8'h0);
      CondE = 4'b0000; settle();
      chk("rst_eq", 8'(CondExE), 8'h0);
      CondE = 4'b0001; settle();
      chk("rst_ne", 8'(CondExE), 8'h1);

      // group write gating
      CondE = 4'b1110; FlagWriteE = 2'b10; ALUFlags = 4'b1111;
      cyc();
      chk("grp_hi", 8'(Flags), 8'hC);
      CondE = 4'b0000; FlagWriteE = 2'b01; settle();
      chk("grp_eq_pass", 8'(CondExE), 8'h1);
      cyc();
      chk("grp_lo", 8'(Flags), 8'hF);
      CondE = 4'b0001; FlagWriteE = 2'b11; ALUFlags = 4'b0000; settle();
      chk("grp_ne_fail", 8'(CondExE), 8'h0);
      cyc();
      chk("grp_nowrite", 8'(Flags), 8'hF);

      // stall and flush
      CondE = 4'b1110; StallE = 1; FlagWriteE = 2'b11; ALUFlags = 4'b0101;
      cyc();
      chk("stall_flags", 8'(Flags), 8'hF);
      StallE = 0; FlushE = 1; settle();
      chk("flush_cex", 8'(CondExE), 8'h0);
      cyc();
      chk("flush_flags", 8'(Flags), 8'hF);
      FlushE = 0; FlagWriteE = 0;

      // invalid IT lengths are ordinary instructions
      ITStartE = 1; ITCondE = 4'b0000; ITLenE = 3'd0; ITMaskE = 4'b1111;
      cyc();
      chk("itlen0", 8'(ITActive), 8'h0);
      ITLenE = 3'd5;
      cyc();
      chk("itlen5", 8'(ITActive), 8'h0);

      // IT block, Z=1, EQ, len 3, mask 0101 -> 1,0,1
      ITLenE = 3'd3; ITMaskE = 4'b0101; CondE = 4'b1110; settle();
      chk("it_start_cex", 8'(CondExE), 8'h1);
      cyc();
      ITStartE = 0;
      chk("it_act", 8'(ITActive), 8'h1);
      chk("it_rem3", 8'(ITRemain), 8'h3);
      CondE = 4'b0001; settle();
      chk("it_slot0", 8'(CondExE), 8'h1);
      cyc();
      chk("it_rem2", 8'(ITRemain), 8'h2);
      CondE = 4'b1110; settle();
      chk("it_slot1", 8'(CondExE), 8'h0);
      StallE = 1;
      cyc();
      chk("it_stall_rem", 8'(ITRemain), 8'h2);
      chk("it_stall_act", 8'(ITActive), 8'h1);
      StallE = 0; settle();
      chk("it_slot1b", 8'(CondExE), 8'h0);
      cyc();
      chk("it_rem1", 8'(ITRemain), 8'h1);
      CondE = 4'b0001; settle();
      chk("it_slot2", 8'(CondExE), 8'h1);
      cyc();
      chk("it_done_act", 8'(ITActive), 8'h0);
      chk("it_done_rem", 8'(ITRemain), 8'h0);
      chk("it_after_ne", 8'(CondExE), 8'h0);

      // save/restore
      CondE = 4'b1110; FlagWriteE = 2'b11; ALUFlags = 4'b1010;
      cyc();
      chk("sr_set", 8'(Flags), 8'hA);
      FlagWriteE = 0; SaveE = 1;
      cyc();
      SaveE = 0; FlagWriteE = 2'b11; ALUFlags = 4'b0001;
      cyc();
      chk("sr_mod", 8'(Flags), 8'h1);
      RestoreE = 1; ALUFlags = 4'b0110;
      cyc();
      chk("sr_restore", 8'(Flags), 8'hA);
      RestoreE = 0; ALUFlags = 4'b0011;
      cyc();
      chk("sr_pre_swap", 8'(Flags), 8'h3);
      FlagWriteE = 0; SaveE = 1; RestoreE = 1;
      cyc();
      chk("sr_swap_f", 8'(Flags), 8'hA);
      SaveE = 0;
      cyc();
      chk("sr_swap_s", 8'(Flags), 8'h3);
      RestoreE = 0; SaveE = 1; FlagWriteE = 2'b11; ALUFlags = 4'b0100;
      cyc();
      chk("sr_save_wr", 8'(Flags), 8'h4);
      SaveE = 0; FlagWriteE = 0; RestoreE = 1;
      cyc();
      chk("sr_old_val", 8'(Flags), 8'h3);
      RestoreE = 0;

      // condition table on N=0 Z=0 C=1 V=1
      ccode = '{4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100,
                4'b1101, 4'b0010, 4'b0110, 4'b0100, 4'b1111};
      cexp  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 10; i++) begin
         CondE = ccode[i]; settle();
         chk($sformatf("cond_%b", ccode[i]), 8'(CondExE), 8'(cexp[i]));
      end

      // reset mid-IT
      CondE = 4'b1110; ITStartE = 1; ITCondE = 4'b0000;
      ITLenE = 3'd4; ITMaskE = 4'b1111;
      cyc();
      ITStartE = 0;
      chk("mid_rem4", 8'(ITRemain), 8'h4);
      chk("mid_override", 8'(CondExE), 8'h0);
      cyc(); cyc();
      chk("mid_rem2", 8'(ITRemain), 8'h2);
      reset = 1;
      cyc();
      reset = 0; settle();
      chk("mid_rst_act", 8'(ITActive), 8'h0);
      chk("mid_rst_rem", 8'(ITRemain), 8'h0);
      chk("mid_rst_flags", 8'(Flags), 8'h0);
      CondE = 4'b0001; settle();
      chk("mid_rst_ne", 8'(CondExE), 8'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
